// File: rtl/nibble_word_packer.sv
// -----------------------------------------------------------------------------
// nibble_word_packer
//
// Collects a stream of 4-bit nibbles (from the shift-register pipeline output)
// into NIBBLES-wide words and presents each word on a valid/ready port.
// The assembly register (acc) and a one-word output buffer (out_data) allow
// the next word to be assembled while the previous one waits downstream.
// A one-cycle flush pulse closes a partial word; unfilled slots are zero.
//
// Parameters
//   NIBBLES    nibbles per word (>= 2); word width = 4*NIBBLES
//   MSB_FIRST  0: first nibble lands in bits[3:0]
//              1: first nibble lands in the top nibble of the word
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   in_data   in   nibble to pack
//   in_vld    in   in_data valid this cycle
//   in_rdy    out  packer can accept a nibble (transfer = in_vld & in_rdy)
//   flush     in   one-cycle pulse closing the current partial word
//   out_data  out  assembled word
//   out_cnt   out  number of valid nibbles in out_data
//   out_vld   out  out_data/out_cnt valid
//   out_rdy   in   consumer accepts (transfer = out_vld & out_rdy)
// -----------------------------------------------------------------------------
module nibble_word_packer #(
    parameter int NIBBLES   = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [3:0]                     in_data,
    input  logic                           in_vld,
    output logic                           in_rdy,
    input  logic                           flush,
    output logic [4*NIBBLES-1:0]           out_data,
    output logic [$clog2(NIBBLES+1)-1:0]   out_cnt,
    output logic                           out_vld,
    input  logic                           out_rdy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(NIBBLES - 1);

    // Assembly state. cnt is the next free slot; held_cnt remembers the
    // nibble count of a closed word parked in acc while the output is busy.
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic [CW-1:0] held_cnt;
    logic          acc_full;

    logic          accept;
    logic          obuf_free;
    logic          close;
    logic [W-1:0]  word_next;
    logic [CW-1:0] cnt_next;

    // A parked word blocks the input until it moves to the output buffer.
    assign in_rdy    = !acc_full;
    assign accept    = in_vld && in_rdy;
    // The output buffer may drain and reload on the same edge.
    assign obuf_free = !out_vld || out_rdy;
    assign cnt_next  = cnt + CW'(accept);

    // A word closes when its last slot fills, or on a flush that has at least
    // one nibble to emit (already held or arriving this cycle). A flush while
    // a word is parked is ignored; no nibble can arrive then either.
    assign close = !acc_full &&
                   ((accept && (cnt == LAST_SLOT)) ||
                    (flush && ((cnt != '0) || accept)));

    // Current word with this cycle's nibble merged into slot cnt.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        word_next = acc;
        if (accept) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (cnt == CW'(i)) begin
                    if (MSB_FIRST) begin
                        word_next[W-4-4*i +: 4] = in_data;
                    end else begin
                        word_next[4*i +: 4] = in_data;
                    end
                end
            end
        end
    end

    // NOTE: all state updates below use non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            held_cnt <= '0;
            acc_full <= 1'b0;
            out_data <= '0;
            out_cnt  <= '0;
            out_vld  <= 1'b0;
        end else begin
            // Default: a word accepted downstream leaves the buffer empty
            // unless one of the branches below reloads it on this edge.
            if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end

            if (acc_full) begin
                // Move the parked word out as soon as the buffer frees up.
                if (obuf_free) begin
                    out_data <= acc;
                    out_cnt  <= held_cnt;
                    out_vld  <= 1'b1;
                    acc      <= '0;
                    acc_full <= 1'b0;
                end
            end else if (close) begin
                cnt <= '0;
                if (obuf_free) begin
                    out_data <= word_next;
                    out_cnt  <= cnt_next;
                    out_vld  <= 1'b1;
                    acc      <= '0;
                end else begin
                    acc      <= word_next;
                    held_cnt <= cnt_next;
                    acc_full <= 1'b1;
                end
            end else if (accept) begin
                acc <= word_next;
                cnt <= cnt_next;
            end
        end
    end

endmodule
